// File: rtl/data_mem_unit.sv
// Data-side memory for the 3-stage RV32I core: word RAM with byte-lane stores plus a
// small MMIO page (GPIO, 64-bit cycle counter, store counter, sticky misalignment error).
module data_mem_unit #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_FF00,
    parameter logic [63:0] CYCLE_INIT  = 64'd0
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [31:0] MEM_addr,
    input  logic [31:0] MEM_WR_out,
    input  logic [2:0]  MEM_type,
    input  logic        MEM_rd_en,
    input  logic        MEM_wr_en,
    output logic [31:0] MEM_data,
    output logic [31:0] gpio_out,
    output logic        misalign_err,
    output logic [31:0] err_addr
);

    localparam int AW = $clog2(DEPTH_WORDS);

    localparam logic [7:0] OFF_GPIO  = 8'h00;
    localparam logic [7:0] OFF_CYCLO = 8'h04;
    localparam logic [7:0] OFF_CYCHI = 8'h08;
    localparam logic [7:0] OFF_SCNT  = 8'h0C;
    localparam logic [7:0] OFF_ERR   = 8'h10;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0] gpio_q, gpio_d;
    logic        err_q, err_d;
    logic [31:0] errAddr_q, errAddr_d;
    logic [63:0] cycle_q, cycle_d;
    logic [31:0] snap_q, snap_d;
    logic [31:0] storeCnt_q, storeCnt_d;

    logic [1:0]    sizeSel;
    logic          isMmio;
    logic [7:0]    mmioOff;
    logic          sizeOk;
    logic          legal;
    logic [AW-1:0] ramIdx;
    logic [4:0]    laneShift;
    logic [31:0]   ramWord;
    logic [31:0]   sizeMask;
    logic [31:0]   ramLoad;
    logic [31:0]   mmioLoad;
    logic [3:0]    byteEn;
    logic [31:0]   wdata;
    logic          ramWe;
    logic          mmioWe;
    logic          accessBad;
    logic          unusedTypeBit;

    assign unusedTypeBit = MEM_type[2];

    assign sizeSel   = MEM_type[1:0];
    assign isMmio    = (MEM_addr[31:8] == MMIO_BASE[31:8]);
    assign mmioOff   = MEM_addr[7:0];
    assign ramIdx    = MEM_addr[AW+1:2];
    assign laneShift = {MEM_addr[1:0], 3'b000};
    assign ramWord   = mem[ramIdx];

    // MMIO only takes aligned words; RAM takes any naturally aligned byte/half/word
    always_comb begin
        sizeOk   = 1'b0;
        sizeMask = 32'h0000_0000;
        byteEn   = 4'b0000;
        unique case (sizeSel)
            2'b00: begin
                sizeOk   = 1'b1;
                sizeMask = 32'h0000_00FF;
                byteEn   = 4'b0001 << MEM_addr[1:0];
            end
            2'b01: begin
                sizeOk   = ~MEM_addr[0];
                sizeMask = 32'h0000_FFFF;
                byteEn   = 4'b0011 << MEM_addr[1:0];
            end
            2'b10: begin
                sizeOk   = (MEM_addr[1:0] == 2'b00);
                sizeMask = 32'hFFFF_FFFF;
                byteEn   = 4'b1111;
            end
            default: begin
                sizeOk   = 1'b0;
                sizeMask = 32'h0000_0000;
                byteEn   = 4'b0000;
            end
        endcase
    end

    assign legal     = sizeOk && (!isMmio || (sizeSel == 2'b10));
    assign accessBad = (MEM_rd_en || MEM_wr_en) && !legal;
    assign wdata     = MEM_WR_out << laneShift;
    assign ramWe     = MEM_wr_en && legal && !isMmio && !Reset;
    assign mmioWe    = MEM_wr_en && legal && isMmio;
    assign ramLoad   = (ramWord >> laneShift) & sizeMask;

    always_comb begin
        mmioLoad = 32'h0000_0000;
        unique case (mmioOff)
            OFF_GPIO:  mmioLoad = gpio_q;
            OFF_CYCLO: mmioLoad = cycle_q[31:0];
            OFF_CYCHI: mmioLoad = snap_q;
            OFF_SCNT:  mmioLoad = storeCnt_q;
            OFF_ERR:   mmioLoad = errAddr_q;
            default:   mmioLoad = 32'h0000_0000;
        endcase
    end

    assign MEM_data = (Reset || !MEM_rd_en || !legal) ? 32'h0000_0000 :
                      (isMmio ? mmioLoad : ramLoad);

    // RAM contents survive reset; only the write strobe is gated by it
    always_ff @(posedge CLK) begin
        if (ramWe) begin
            for (int b = 0; b < 4; b++) begin
                if (byteEn[b]) begin
                    mem[ramIdx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        gpio_d     = gpio_q;
        err_d      = err_q;
        errAddr_d  = errAddr_q;
        cycle_d    = cycle_q + 64'd1;
        snap_d     = snap_q;
        storeCnt_d = storeCnt_q;

        if (mmioWe && (mmioOff == OFF_GPIO)) begin
            gpio_d = MEM_WR_out;
        end
        if (mmioWe && (mmioOff == OFF_ERR)) begin
            err_d     = 1'b0;
            errAddr_d = 32'h0000_0000;
        end
        if (MEM_rd_en && legal && isMmio && (mmioOff == OFF_CYCLO)) begin
            snap_d = cycle_q[63:32];
        end
        if (ramWe && (storeCnt_q != 32'hFFFF_FFFF)) begin
            storeCnt_d = storeCnt_q + 32'd1;
        end
        // A fresh error overrides a same-cycle clear and re-arms address capture
        if (accessBad) begin
            err_d = 1'b1;
            if (!err_q || (mmioWe && (mmioOff == OFF_ERR))) begin
                errAddr_d = MEM_addr;
            end
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            gpio_q     <= 32'h0000_0000;
            err_q      <= 1'b0;
            errAddr_q  <= 32'h0000_0000;
            cycle_q    <= CYCLE_INIT;
            snap_q     <= 32'h0000_0000;
            storeCnt_q <= 32'h0000_0000;
        end else begin
            gpio_q     <= gpio_d;
            err_q      <= err_d;
            errAddr_q  <= errAddr_d;
            cycle_q    <= cycle_d;
            snap_q     <= snap_d;
            storeCnt_q <= storeCnt_d;
        end
    end

    assign gpio_out     = gpio_q;
    assign misalign_err = err_q;
    assign err_addr     = errAddr_q;

endmodule

// File: tb/tb_data_mem_unit.sv
// Bench for data_mem_unit: directed scenarios plus random traffic, all checked against
// a byte-addressed reference model of the RAM and MMIO page.
module tb_data_mem_unit;

    localparam int          DEPTH     = 256;
    localparam logic [63:0] CYC_INIT  = 64'h0000_0000_FFFF_F000;
    localparam logic [31:0] MMIO      = 32'hFFFF_FF00;
    localparam logic [2:0]  T_B       = 3'b000;
    localparam logic [2:0]  T_H       = 3'b001;
    localparam logic [2:0]  T_W       = 3'b010;

    logic        CLK;
    logic        Reset;
    logic [31:0] MEM_addr;
    logic [31:0] MEM_WR_out;
    logic [2:0]  MEM_type;
    logic        MEM_rd_en;
    logic        MEM_wr_en;
    logic [31:0] MEM_data;
    logic [31:0] gpio_out;
    logic        misalign_err;
    logic [31:0] err_addr;

    int assertCount = 0;
    int failCount   = 0;

    // reference model state
    logic [7:0]  ramB [DEPTH*4];
    logic [31:0] mGpio;
    logic        mErr;
    logic [31:0] mErrAddr;
    logic [63:0] mCyc;
    logic [31:0] mSnap;
    logic [31:0] mScnt;

    data_mem_unit #(
        .DEPTH_WORDS(DEPTH),
        .MMIO_BASE  (MMIO),
        .CYCLE_INIT (CYC_INIT)
    ) dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .MEM_addr    (MEM_addr),
        .MEM_WR_out  (MEM_WR_out),
        .MEM_type    (MEM_type),
        .MEM_rd_en   (MEM_rd_en),
        .MEM_wr_en   (MEM_wr_en),
        .MEM_data    (MEM_data),
        .gpio_out    (gpio_out),
        .misalign_err(misalign_err),
        .err_addr    (err_addr)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic isMmioAddr(input logic [31:0] a);
        return a[31:8] == MMIO[31:8];
    endfunction

    function automatic logic legalAcc(input logic [31:0] a, input logic [2:0] t);
        if (isMmioAddr(a)) return (t[1:0] == 2'd2) && (a % 4 == 0);
        case (t[1:0])
            2'd0:    return 1'b1;
            2'd1:    return (a % 2 == 0);
            2'd2:    return (a % 4 == 0);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] modelLoad(input logic rd, input logic [31:0] a, input logic [2:0] t);
        logic [31:0] v;
        int base;
        v = 0;
        if (!rd || !legalAcc(a, t)) return 0;
        if (isMmioAddr(a)) begin
            case (a[7:0])
                8'h00:   return mGpio;
                8'h04:   return mCyc[31:0];
                8'h08:   return mSnap;
                8'h0C:   return mScnt;
                8'h10:   return mErrAddr;
                default: return 0;
            endcase
        end
        base = int'(a % (DEPTH * 4));
        for (int i = 0; i < (1 << t[1:0]); i++) v[8*i +: 8] = ramB[base + i];
        return v;
    endfunction

    task automatic modelEdge(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] d, input logic [2:0] t);
        logic ok;
        logic oldErr;
        int base;
        ok     = legalAcc(a, t);
        oldErr = mErr;
        if (ok && wr) begin
            if (isMmioAddr(a)) begin
                if (a[7:0] == 8'h00) mGpio = d;
                if (a[7:0] == 8'h10) begin
                    mErr     = 1'b0;
                    mErrAddr = 0;
                end
            end else begin
                base = int'(a % (DEPTH * 4));
                for (int i = 0; i < (1 << t[1:0]); i++) ramB[base + i] = d[8*i +: 8];
                if (mScnt != 32'hFFFF_FFFF) mScnt = mScnt + 1;
            end
        end
        if (ok && rd && isMmioAddr(a) && a[7:0] == 8'h04) mSnap = mCyc[63:32];
        if ((rd || wr) && !ok) begin
            if (!oldErr) mErrAddr = a;
            mErr = 1'b1;
        end
        mCyc = mCyc + 1;
    endtask

    task automatic modelReset();
        mGpio    = 0;
        mErr     = 0;
        mErrAddr = 0;
        mCyc     = CYC_INIT;
        mSnap    = 0;
        mScnt    = 0;
    endtask

    // One cycle: drive at posedge+1, check before the next edge, advance the model after it
    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] a,
                                 input logic [31:0] d, input logic [2:0] t, output logic [31:0] seen);
        MEM_rd_en  = rd;
        MEM_wr_en  = wr;
        MEM_addr   = a;
        MEM_WR_out = d;
        MEM_type   = t;
        #3;
        seen = MEM_data;
        checkOutput("load", MEM_data, modelLoad(rd, a, t));
        checkOutput("gpio", gpio_out, mGpio);
        checkOutput("err_flag", {31'd0, misalign_err}, {31'd0, mErr});
        checkOutput("err_addr", err_addr, mErrAddr);
        @(posedge CLK);
        modelEdge(rd, wr, a, d, t);
        #1;
    endtask

    task automatic idle();
        logic [31:0] s;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, T_W, s);
    endtask

    initial begin
        logic [31:0] s;
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  t;
        int guard;

        Reset = 1'b1;
        MEM_rd_en = 1'b1;
        MEM_wr_en = 1'b0;
        MEM_addr = MMIO;
        MEM_WR_out = 32'h0;
        MEM_type = T_W;
        modelReset();
        @(posedge CLK);
        @(posedge CLK);
        #3;
        checkOutput("rst_data", MEM_data, 32'h0);
        checkOutput("rst_gpio", gpio_out, 32'h0);
        checkOutput("rst_err", {31'd0, misalign_err}, 32'h0);
        checkOutput("rst_erraddr", err_addr, 32'h0);
        @(posedge CLK);
        #1;
        Reset = 1'b0;

        for (int w = 0; w < DEPTH; w++) applyStimulus(1'b0, 1'b1, w * 4, $urandom, T_W, s);

        applyStimulus(1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, T_W, s);
        applyStimulus(1'b1, 1'b0, 32'h101, 32'h0, T_B, s);
        checkOutput("t1_lb", s, 32'h0000_00BE);
        applyStimulus(1'b1, 1'b0, 32'h102, 32'h0, T_H, s);
        checkOutput("t1_lh", s, 32'h0000_DEAD);

        applyStimulus(1'b0, 1'b1, 32'h103, 32'h55, T_B, s);
        applyStimulus(1'b1, 1'b0, 32'h100, 32'h0, T_W, s);
        checkOutput("t2_lw", s, 32'h55AD_BEEF);
        applyStimulus(1'b1, 1'b0, MMIO + 32'h0C, 32'h0, T_W, s);
        checkOutput("t2_scnt", s, DEPTH + 2);

        applyStimulus(1'b1, 1'b0, 32'h102, 32'h0, T_W, s);
        checkOutput("t3_lw_mis", s, 32'h0);
        checkOutput("t3_flag", {31'd0, misalign_err}, 32'h1);
        checkOutput("t3_addr", err_addr, 32'h102);
        applyStimulus(1'b0, 1'b1, 32'h205, 32'h1234, T_H, s);
        checkOutput("t3_sticky", err_addr, 32'h102);
        applyStimulus(1'b0, 1'b1, MMIO + 32'h10, $urandom, T_W, s);
        checkOutput("t3_clr_flag", {31'd0, misalign_err}, 32'h0);
        checkOutput("t3_clr_addr", err_addr, 32'h0);

        guard = 0;
        while (mCyc[31:0] != 32'hFFFF_FFFF && guard < 5000) begin
            applyStimulus(1'b1, 1'b0, MMIO + 32'h04, 32'h0, T_W, s);
            guard++;
        end
        applyStimulus(1'b1, 1'b0, MMIO + 32'h04, 32'h0, T_W, s);
        checkOutput("t4_lo", s, 32'hFFFF_FFFF);
        applyStimulus(1'b1, 1'b0, MMIO + 32'h08, 32'h0, T_W, s);
        checkOutput("t4_hi0", s, 32'h0);
        applyStimulus(1'b1, 1'b0, MMIO + 32'h04, 32'h0, T_W, s);
        applyStimulus(1'b1, 1'b0, MMIO + 32'h08, 32'h0, T_W, s);
        checkOutput("t4_hi1", s, 32'h1);

        applyStimulus(1'b0, 1'b1, 32'h200, 32'h0, T_W, s);
        applyStimulus(1'b1, 1'b1, 32'h200, 32'h1234_5678, T_W, s);
        checkOutput("t6_rdwr", s, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h200, 32'h0, T_W, s);
        checkOutput("t6_lw", s, 32'h1234_5678);

        applyStimulus(1'b0, 1'b1, MMIO, 32'h0000_A5A5, T_W, s);
        checkOutput("t5_gpio", gpio_out, 32'h0000_A5A5);
        applyStimulus(1'b0, 1'b1, MMIO, 32'h77, T_B, s);
        checkOutput("t5_sb_gpio", gpio_out, 32'h0000_A5A5);
        checkOutput("t5_sb_err", {31'd0, misalign_err}, 32'h1);

        // asynchronous reset between edges with a store pending
        MEM_rd_en  = 1'b1;
        MEM_wr_en  = 1'b1;
        MEM_addr   = 32'h300;
        MEM_WR_out = 32'hCAFE_F00D;
        MEM_type   = T_W;
        #2;
        Reset = 1'b1;
        #1;
        checkOutput("t5_async_gpio", gpio_out, 32'h0);
        checkOutput("t5_async_err", {31'd0, misalign_err}, 32'h0);
        checkOutput("t5_async_data", MEM_data, 32'h0);
        modelReset();
        @(posedge CLK);
        #1;
        Reset = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'h300, 32'h0, T_W, s);
        applyStimulus(1'b1, 1'b0, MMIO + 32'h0C, 32'h0, T_W, s);
        checkOutput("t5_scnt_rst", s, 32'h0);

        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 9) < 3) a = MMIO + $urandom_range(0, 31);
            else a = $urandom & 32'h0000_0FFF;
            if ($urandom_range(0, 3) != 0 && isMmioAddr(a)) a = a & 32'hFFFF_FFFC;
            t = 3'($urandom_range(0, 7));
            d = $urandom;
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, d, t, s);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
